dac_sample_scheduler: RTL

- Upstream feeder for the LTC1668 parallel DAC interface.
- Buffers 16-bit samples arriving over a valid/ready stream in a small FIFO.
- Paces them out at a programmable sample rate: one start pulse plus data per tick, never issued while the DAC interface reports busy.
- Reports FIFO level, underruns (tick with no sample) and overrate (tick arriving while the previous write is still settling).

---
 rtl/dac_sample_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dac_sample_scheduler.sv
// ---------------------------------------------------------------------------
// dac_sample_scheduler
//
// Upstream feeder for the LTC1668 parallel DAC interface. Samples arrive over
// a valid/ready stream and are buffered in a small FIFO. A programmable
// divider produces sample ticks, and each tick issues one FIFO entry to the
// DAC interface as a single-cycle start pulse plus data, never while the DAC
// interface reports busy. Ticks that find the FIFO empty report an underrun;
// ticks that arrive while one is already pending report an overrate.
//
// Optional feature (macro DAC_OFFSET_BINARY_EN):
//   defined   - samples are two's complement; dac_data has bit 15 inverted
//               (offset binary for the DAC).
//   undefined - dac_data is the popped sample unchanged (straight binary).
//   The FIFO always stores the raw sample; conversion is at the output only.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous, active-low reset
//   enable         1 = generate sample ticks, 0 = paced output halted
//   rate_div       tick period minus one, in clk cycles
//   clear_flags    1-cycle pulse clearing the sticky flags
//   s_valid        upstream sample valid
//   s_data         upstream sample
//   s_ready        FIFO can accept a sample
//   dac_busy       busy from the DAC interface
//   dac_start      1-cycle write request to the DAC interface
//   dac_data       sample presented with dac_start, held until next issue
//   fifo_level     current occupancy, 0..FIFO_DEPTH
//   underrun       1-cycle pulse: tick with FIFO empty
//   overrate       1-cycle pulse: tick dropped, one was already pending
//   underrun_flag  sticky underrun
//   overrate_flag  sticky overrate
// ---------------------------------------------------------------------------
module dac_sample_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              clear_flags,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    output logic              s_ready,
    input  logic              dac_busy,
    output logic              dac_start,
    output logic [15:0]       dac_data,
    output logic [ADDR_W:0]   fifo_level,
    output logic              underrun,
    output logic              overrate,
    output logic              underrun_flag,
    output logic              overrate_flag
);

    typedef enum logic [1:0] {IDLE, RUN, ACK_WAIT, BUSY_WAIT} state_t;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic [ADDR_W-1:0] wrPtr_q, rdPtr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              pend_q, pend_d;
    logic              ackCnt_q;
    logic              dacStart_q;
    logic [15:0]       dacData_q;
    logic              underrun_q, overrate_q;
    logic              underrunFlag_q, overrateFlag_q;
    logic [15:0]       mem [FIFO_DEPTH];

    logic              tick, push, issue, underrunEv, overrateEv, fifoEmpty;
    logic [15:0]       headData;

    // Next-state logic for the divider, pending tick, FIFO level and FSM.
    // A tick in the current cycle counts as pending, which gives the
    // one-cycle tick-to-start latency. A tick that meets an already pending
    // tick is dropped (overrate), even if that pending tick issues now.
    always_comb begin
        tick       = enable && (divCnt_q == rate_div);
        divCnt_d   = (enable && !tick) ? divCnt_q + DIV_W'(1) : '0;
        fifoEmpty  = (level_q == '0);
        push       = s_valid && (level_q != FULL_LEVEL);
        issue      = (state_q == RUN) && enable && (pend_q || tick) && !fifoEmpty;
        underrunEv = (state_q == RUN) && enable && (pend_q || tick) && fifoEmpty;
        overrateEv = tick && pend_q;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable)    state_d = IDLE;
                else if (issue) state_d = ACK_WAIT;
            end
            // Second cycle without busy means the DAC never acknowledged.
            ACK_WAIT: begin
                if (dac_busy)      state_d = BUSY_WAIT;
                else if (ackCnt_q) state_d = enable ? RUN : IDLE;
            end
            BUSY_WAIT: begin
                if (!dac_busy) state_d = enable ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        pend_d = pend_q;
        if (issue || underrunEv || (state_d == IDLE)) pend_d = 1'b0;
        else if (tick)                                 pend_d = 1'b1;

        level_d = level_q;
        if (push && !issue)      level_d = level_q + (ADDR_W+1)'(1);
        else if (!push && issue) level_d = level_q - (ADDR_W+1)'(1);

`ifdef DAC_OFFSET_BINARY_EN
        headData = {~mem[rdPtr_q][15], mem[rdPtr_q][14:0]};
`else
        headData = mem[rdPtr_q];
`endif
    end

    // Sample storage; contents need no reset since occupancy is tracked
    // by the level register.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr_q] <= s_data;
    end

    // Handshake FSM with its registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ackCnt_q   <= 1'b0;
            dacStart_q <= 1'b0;
            dacData_q  <= '0;
            underrun_q <= 1'b0;
            overrate_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ackCnt_q   <= (state_q == ACK_WAIT) && (state_d == ACK_WAIT);
            dacStart_q <= issue;
            if (issue) dacData_q <= headData;
            underrun_q <= underrunEv;
            overrate_q <= overrateEv;
        end
    end

    // Divider, pending tick, FIFO pointers/level and sticky flags.
    // A set event in the same cycle as clear_flags keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divCnt_q       <= '0;
            pend_q         <= 1'b0;
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            level_q        <= '0;
            underrunFlag_q <= 1'b0;
            overrateFlag_q <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            pend_q   <= pend_d;
            level_q  <= level_d;
            if (push)  wrPtr_q <= wrPtr_q + ADDR_W'(1);
            if (issue) rdPtr_q <= rdPtr_q + ADDR_W'(1);
            if (underrunEv)       underrunFlag_q <= 1'b1;
            else if (clear_flags) underrunFlag_q <= 1'b0;
            if (overrateEv)       overrateFlag_q <= 1'b1;
            else if (clear_flags) overrateFlag_q <= 1'b0;
        end
    end

    assign s_ready       = (level_q != FULL_LEVEL);
    assign dac_start     = dacStart_q;
    assign dac_data      = dacData_q;
    assign fifo_level    = level_q;
    assign underrun      = underrun_q;
    assign overrate      = overrate_q;
    assign underrun_flag = underrunFlag_q;
    assign overrate_flag = overrateFlag_q;

endmodule
